// File: rtl/pio_in_edge_irq_if.sv
// +--------------------------------------------------------------------------+
// | pio_in_edge_irq_if : Avalon-MM slave bus bundle plus interrupt line for   |
// |                      the edge-capturing input PIO.                        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pio_in_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

`default_nettype wire

// File: rtl/pio_in_edge_irq.sv
// +--------------------------------------------------------------------------+
// | pio_in_edge_irq : parametrised input PIO with per-bit rise/fall edge      |
// |                   capture, W1C clear and level interrupt.                 |
// | Optional debounce filter enabled by defining PIO_IN_DEBOUNCE_EN.          |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module pio_in_edge_irq #(
    parameter int               WIDTH       = 18,
    parameter int               SYNC_STAGES = 2,
    parameter int               DB_CNT_W    = 16,
    parameter logic [WIDTH-1:0] RISE_RST    = '0,
    parameter logic [WIDTH-1:0] FALL_RST    = {WIDTH{1'b1}}
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [WIDTH-1:0] in_port,
    pio_in_edge_irq_if.slave      bus
);

    localparam logic [2:0] c_ADDR_DATA     = 3'd0;
    localparam logic [2:0] c_ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] c_ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] c_ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] c_ADDR_DB_LIMIT = 3'd5;
    localparam logic [2:0] c_ADDR_IRQ_PEND = 3'd6;

    logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]    w_sync;
    logic [WIDTH-1:0]    r_filt;
    logic [WIDTH-1:0]    w_filt_nxt;
    logic [WIDTH-1:0]    r_filt_d;
    logic [WIDTH-1:0]    w_edge;
    logic [WIDTH-1:0]    r_edge_cap;
    logic [WIDTH-1:0]    w_clr;
    logic [WIDTH-1:0]    r_irq_mask;
    logic [WIDTH-1:0]    r_rise_en;
    logic [WIDTH-1:0]    r_fall_en;
    logic [DB_CNT_W-1:0] w_db_limit;
    logic                w_wr;
    logic [31:0]         w_rdata;
    logic [31:0]         r_rdata;
    logic                r_irq;

    assign w_wr = bus.chipselect & ~bus.write_n;

    // Metastability chain; only the last stage is consumed downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] r_db_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_limit <= '0;
        end else if (w_wr && (bus.address == c_ADDR_DB_LIMIT)) begin
            r_db_limit <= bus.writedata[DB_CNT_W-1:0];
        end
    end

    assign w_db_limit = r_db_limit;

    // Compare uses >= so a limit lowered mid-count takes effect at once;
    // a zero limit therefore degenerates to a straight pass-through.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        logic [DB_CNT_W-1:0] r_cnt;
        logic [DB_CNT_W-1:0] w_cnt_inc;
        logic                w_diff;
        logic                w_hit;

        assign w_diff    = w_sync[gi] != r_filt[gi];
        assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + DB_CNT_W'(1);
        assign w_hit     = w_diff && (w_cnt_inc >= r_db_limit);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
            end else if (!w_diff || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end

        assign w_filt_nxt[gi] = w_hit ? w_sync[gi] : r_filt[gi];
    end
`else
    assign w_filt_nxt = w_sync;
    assign w_db_limit = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt   <= '0;
            r_filt_d <= '0;
        end else begin
            r_filt   <= w_filt_nxt;
            r_filt_d <= r_filt;
        end
    end

    assign w_edge = (r_rise_en &  r_filt & ~r_filt_d)
                  | (r_fall_en & ~r_filt &  r_filt_d);

    assign w_clr = (w_wr && (bus.address == c_ADDR_EDGE_CAP))
                 ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rise_en  <= RISE_RST;
            r_fall_en  <= FALL_RST;
            r_irq_mask <= '0;
        end else if (w_wr) begin
            case (bus.address)
                c_ADDR_RISE_EN:  r_rise_en  <= bus.writedata[WIDTH-1:0];
                c_ADDR_IRQ_MASK: r_irq_mask <= bus.writedata[WIDTH-1:0];
                c_ADDR_FALL_EN:  r_fall_en  <= bus.writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // A fresh edge is ORed in after the clear so it survives a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            r_irq      <= |(r_edge_cap & r_irq_mask);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            c_ADDR_DATA:     w_rdata = 32'(r_filt);
            c_ADDR_RISE_EN:  w_rdata = 32'(r_rise_en);
            c_ADDR_IRQ_MASK: w_rdata = 32'(r_irq_mask);
            c_ADDR_EDGE_CAP: w_rdata = 32'(r_edge_cap);
            c_ADDR_FALL_EN:  w_rdata = 32'(r_fall_en);
            c_ADDR_DB_LIMIT: w_rdata = 32'(w_db_limit);
            c_ADDR_IRQ_PEND: w_rdata = 32'(r_edge_cap & r_irq_mask);
            default:         w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign bus.readdata = r_rdata;
    assign bus.irq      = r_irq;

endmodule

`default_nettype wire

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM input PIO for board switches and keys. Generalises the fixed 18-bit falling-edge capture PIO.
- Adds configurable width and synchroniser depth, per-bit rising/falling edge selection, write-1-to-clear edge capture, and an optional per-bit debounce filter.
- Sits as a Qsys slave between board I/O pins and the Nios II interrupt controller.

Parameters:
- WIDTH, 18, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (2..4).
- DB_CNT_W, 16, debounce counter width in bits. Used only with the debounce feature.
- RISE_RST, 0, reset value of rise_en (WIDTH bits).
- FALL_RST, all ones, reset value of fall_en (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous pin inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset (asynchronous, reset_n=0) sets: readdata=0, irq=0, synchroniser chain=0, filtered value=0, edge_capture=0, irq_mask=0, rise_en=RISE_RST, fall_en=FALL_RST, db_limit=0.
- Write condition: chipselect & ~write_n.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync.
- Filtered value filt: equals sync in bypass mode (see Optional Feature).
- filt_d: filt delayed by 1 cycle.
- Edge detect per bit: edge = (rise_en & filt & ~filt_d) | (fall_en & ~filt & filt_d).
- Pin-to-capture latency (bypass): SYNC_STAGES+2 clk from the in_port change to the edge_capture bit set.
- Register map (bits above WIDTH read 0, writes ignored):
  - 0 DATA, RO: filt.
  - 1 RISE_EN, RW.
  - 2 IRQ_MASK, RW.
  - 3 EDGE_CAP, W1C: a written 1 clears that bit, a written 0 leaves it unchanged.
  - 4 FALL_EN, RW.
  - 5 DB_LIMIT, RW, low DB_CNT_W bits. Reads 0 when the feature is absent.
  - 6 IRQ_PEND, RO: edge_capture & irq_mask.
  - 7 reserved, reads 0.
- Read: readdata is updated every clk from address, independent of chipselect. Read latency is 1.
- Edge-capture bit rules:
  - Set on edge; holds until cleared by W1C.
  - Edge and W1C on the same bit in the same cycle: set wins, bit stays 1.
  - W1C of one bit does not affect other bits.
  - Changing rise_en or fall_en never alters already captured bits.
- irq: registered, irq <= |(edge_capture & irq_mask). It asserts 1 clk after the capture bit sets and deasserts 1 clk after the clear or mask write.
- Simultaneous opposite edges on different bits are captured independently.
- If rise_en and fall_en are both 1 for a bit, that bit captures any transition.
- Reset asserted mid-operation clears all state immediately. No edge is reported for the post-reset value while filt=filt_d=0. An input held high through reset produces a rising edge after release if rise_en is set.

Optional Feature:
- Macro: PIO_IN_DEBOUNCE_EN.
- Defined:
  - Each bit has a DB_CNT_W-bit counter.
  - While sync != filt, the counter increments each clk. When the counter reaches db_limit, filt takes sync and the counter resets to 0.
  - While sync == filt, the counter holds 0.
  - db_limit=0 selects bypass (filt=sync every cycle).
  - The counter saturates and never wraps.
  - Writing DB_LIMIT mid-count applies on the next compare.
- Undefined: no counters, filt=sync, DB_LIMIT reads 0 and writes are ignored.

Test Plan:
- Reset defaults: after reset, read addr 2,3,4 -> 0, 0, 0x3FFFF (WIDTH=18); irq=0.
- Falling edge: set IRQ_MASK=0x1, drive in_port[0] 1->0 -> EDGE_CAP=0x1 after SYNC_STAGES+2 clk, irq=1 one clk later. Write 0x1 to addr 3 -> EDGE_CAP=0, irq=0 next clk.
- Rising only: RISE_EN=0x4, FALL_EN=0. Pulse in_port[2] 0->1->0 -> EDGE_CAP=0x4 only. Writing 0x0 to addr 3 leaves it at 0x4.
- Set beats clear: an edge on bit 5 lands in the same cycle as a W1C of 0x20 -> EDGE_CAP bit 5 remains 1.
- Debounce (macro on): DB_LIMIT=10. A 5-clk glitch on in_port[1] -> DATA bit 1 unchanged, no capture. A 12-clk hold -> DATA bit 1 flips after 10 clk of mismatch and the capture bit sets.
- Reset mid-operation: with EDGE_CAP=0x3 and irq=1, pulse reset_n low -> all outputs 0 immediately. in_port held at 0 after release -> no capture.
